// File: rtl/pipe_mips32_pkg.sv
// Shared definitions for the pipe_mips32 core: opcodes, instruction classes,
// pipeline register layouts and the opcode classifier.
// Optional feature macro: MIPS_MUL_EN (MUL opcode active when defined).
package pipe_mips32_pkg;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    typedef enum logic [2:0] {
        RR_ALU,
        RM_ALU,
        LOAD,
        STORE,
        BRANCH,
        HALT,
        NOP
    } op_class_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] ir;
        logic [31:0] npc;
    } if_id_t;

    typedef struct packed {
        logic        valid;
        op_class_e   cls;
        logic [5:0]  op;
        logic [31:0] npc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic        wen;
    } id_ex_t;

    typedef struct packed {
        logic        valid;
        op_class_e   cls;
        logic [31:0] alu_out;
        logic [31:0] b;
        logic [4:0]  dst;
        logic        wen;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        op_class_e   cls;
        logic [31:0] result;
        logic [4:0]  dst;
        logic        wen;
    } mem_wb_t;

    // Unknown opcodes (and MUL when the multiplier is absent) become NOPs,
    // so they never write the register file or memory.
    function automatic op_class_e decode_class(input logic [5:0] op);
        op_class_e c;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: c = RR_ALU;
`ifdef MIPS_MUL_EN
            OP_MUL:                                c = RR_ALU;
`endif
            OP_ADDI, OP_SUBI, OP_SLTI:             c = RM_ALU;
            OP_LW:                                 c = LOAD;
            OP_SW:                                 c = STORE;
            OP_BNEQZ, OP_BEQZ:                     c = BRANCH;
            OP_HLT:                                c = HALT;
            default:                               c = NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipe_mips32_alu.sv
// Combinational EX-stage ALU for pipe_mips32. Loads/stores use it for
// address generation. The multiplier exists only when MIPS_MUL_EN is defined.
module pipe_mips32_alu
    import pipe_mips32_pkg::*;
(
    input  op_class_e   cls_i,
    input  logic [5:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] y_o
);

    // Result select by class then opcode; everything truncates to 32 bits.
    always_comb begin
        y_o = '0;
        case (cls_i)
            RR_ALU, RM_ALU: begin
                case (op_i)
                    OP_ADD, OP_ADDI: y_o = a_i + b_i;
                    OP_SUB, OP_SUBI: y_o = a_i - b_i;
                    OP_AND:          y_o = a_i & b_i;
                    OP_OR:           y_o = a_i | b_i;
                    OP_SLT, OP_SLTI: y_o = {31'b0, $signed(a_i) < $signed(b_i)};
`ifdef MIPS_MUL_EN
                    OP_MUL:          y_o = a_i * b_i;
`endif
                    default:         y_o = '0;
                endcase
            end
            LOAD, STORE: y_o = a_i + b_i;
            default:     y_o = '0;
        endcase
    end

endmodule

// File: rtl/pipe_mips32.sv
// Five-stage in-order MIPS32-subset core (IF, ID, EX, MEM, WB) with a unified
// word-addressed memory Mem and register file Reg. Forwarding into EX from
// EX/MEM (ALU results) and MEM/WB; branches resolve in EX and squash two slots.
// Optional feature macro: MIPS_MUL_EN enables the MUL opcode.
module pipe_mips32
    import pipe_mips32_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 1024,
    parameter int unsigned XLEN      = 32
) (
    input  logic clk,
    input  logic rst_n,
    output logic halted
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);

    // Architectural state, named for hierarchical access
    logic [XLEN-1:0] Reg [0:31];
    logic [XLEN-1:0] Mem [0:MEM_DEPTH-1];
    logic [XLEN-1:0] PC;
    logic            HALTED;
    logic            TAKEN_BRANCH;

    // Fetch stopped because HLT has passed decode
    logic stopped_q;

    if_id_t  if_id_q,  if_id_d;
    id_ex_t  id_ex_q,  id_ex_d;
    ex_mem_t ex_mem_q, ex_mem_d;
    mem_wb_t mem_wb_q, mem_wb_d;

    logic [AW-1:0]   fetch_addr, data_addr;
    logic [XLEN-1:0] pc_d;
    logic            fetch_en, halt_dec, wb_we, mem_we, ex_taken;
    logic [5:0]      id_op;
    logic [4:0]      id_rs, id_rt, id_rd;
    logic [31:0]     id_imm, id_a, id_b;
    op_class_e       id_cls;
    logic [31:0]     ex_a, ex_b, alu_b, alu_y, mem_rdata;

    assign halted = HALTED;

    // WB: register write, suppressed after halt; wen already excludes R0
    assign wb_we = mem_wb_q.valid && mem_wb_q.wen && !HALTED;

    // ID decode; same-cycle WB write is visible to the read (write-first)
    assign id_op  = if_id_q.ir[31:26];
    assign id_rs  = if_id_q.ir[25:21];
    assign id_rt  = if_id_q.ir[20:16];
    assign id_rd  = if_id_q.ir[15:11];
    assign id_imm = {{16{if_id_q.ir[15]}}, if_id_q.ir[15:0]};
    assign id_cls = decode_class(id_op);
    assign id_a   = (id_rs == 5'd0) ? '0 :
                    (wb_we && mem_wb_q.dst == id_rs) ? mem_wb_q.result : Reg[id_rs];
    assign id_b   = (id_rt == 5'd0) ? '0 :
                    (wb_we && mem_wb_q.dst == id_rt) ? mem_wb_q.result : Reg[id_rt];

    // EX operand forwarding; the younger producer in EX/MEM overrides MEM/WB
    always_comb begin
        ex_a = id_ex_q.a;
        ex_b = id_ex_q.b;
        if (mem_wb_q.valid && mem_wb_q.wen && mem_wb_q.dst == id_ex_q.rs) ex_a = mem_wb_q.result;
        if (mem_wb_q.valid && mem_wb_q.wen && mem_wb_q.dst == id_ex_q.rt) ex_b = mem_wb_q.result;
        if (ex_mem_q.valid && ex_mem_q.wen && ex_mem_q.cls != LOAD && ex_mem_q.dst == id_ex_q.rs)
            ex_a = ex_mem_q.alu_out;
        if (ex_mem_q.valid && ex_mem_q.wen && ex_mem_q.cls != LOAD && ex_mem_q.dst == id_ex_q.rt)
            ex_b = ex_mem_q.alu_out;
    end

    assign alu_b    = (id_ex_q.cls == RR_ALU) ? ex_b : id_ex_q.imm;
    assign ex_taken = id_ex_q.valid && (id_ex_q.cls == BRANCH) &&
                      ((id_ex_q.op == OP_BEQZ) ? (ex_a == 32'd0) : (ex_a != 32'd0));

    pipe_mips32_alu u_alu (
        .cls_i (id_ex_q.cls),
        .op_i  (id_ex_q.op),
        .a_i   (ex_a),
        .b_i   (alu_b),
        .y_o   (alu_y)
    );

    // MEM: addresses wrap modulo the memory depth
    assign data_addr = AW'(ex_mem_q.alu_out % MEM_DEPTH);
    assign mem_rdata = Mem[data_addr];
    assign mem_we    = ex_mem_q.valid && (ex_mem_q.cls == STORE) && !HALTED;

    // IF: fetch stops once HLT is decoded, unless that HLT is being squashed
    assign fetch_addr = AW'(PC % MEM_DEPTH);
    assign halt_dec   = if_id_q.valid && (id_cls == HALT) && !ex_taken;
    assign fetch_en   = !HALTED && !stopped_q && !halt_dec;

    // Next-state for PC and every pipeline register
    always_comb begin
        if_id_d  = '0;
        id_ex_d  = '0;
        ex_mem_d = '0;
        mem_wb_d = '0;
        pc_d     = PC;

        if (ex_taken) begin
            pc_d = id_ex_q.npc + id_ex_q.imm;
        end else if (fetch_en) begin
            pc_d          = PC + 32'd1;
            if_id_d.valid = 1'b1;
            if_id_d.ir    = Mem[fetch_addr];
            if_id_d.npc   = PC + 32'd1;
        end

        if (if_id_q.valid && !ex_taken) begin
            id_ex_d.valid = 1'b1;
            id_ex_d.cls   = id_cls;
            id_ex_d.op    = id_op;
            id_ex_d.npc   = if_id_q.npc;
            id_ex_d.a     = id_a;
            id_ex_d.b     = id_b;
            id_ex_d.imm   = id_imm;
            id_ex_d.rs    = id_rs;
            id_ex_d.rt    = id_rt;
            id_ex_d.dst   = (id_cls == RR_ALU) ? id_rd : id_rt;
            id_ex_d.wen   = (id_cls == RR_ALU || id_cls == RM_ALU || id_cls == LOAD) &&
                            (id_ex_d.dst != 5'd0);
        end

        ex_mem_d.valid   = id_ex_q.valid;
        ex_mem_d.cls     = id_ex_q.cls;
        ex_mem_d.alu_out = alu_y;
        ex_mem_d.b       = ex_b;
        ex_mem_d.dst     = id_ex_q.dst;
        ex_mem_d.wen     = id_ex_q.valid && id_ex_q.wen;

        mem_wb_d.valid   = ex_mem_q.valid;
        mem_wb_d.cls     = ex_mem_q.cls;
        mem_wb_d.result  = (ex_mem_q.cls == LOAD) ? mem_rdata : ex_mem_q.alu_out;
        mem_wb_d.dst     = ex_mem_q.dst;
        mem_wb_d.wen     = ex_mem_q.valid && ex_mem_q.wen;
    end

    // Pipeline and control state; everything freezes once HALTED is set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC           <= '0;
            HALTED       <= 1'b0;
            TAKEN_BRANCH <= 1'b0;
            stopped_q    <= 1'b0;
            if_id_q      <= '0;
            id_ex_q      <= '0;
            ex_mem_q     <= '0;
            mem_wb_q     <= '0;
        end else if (!HALTED) begin
            PC           <= pc_d;
            HALTED       <= mem_wb_q.valid && (mem_wb_q.cls == HALT);
            TAKEN_BRANCH <= ex_taken;
            stopped_q    <= stopped_q | halt_dec;
            if_id_q      <= if_id_d;
            id_ex_q      <= id_ex_d;
            ex_mem_q     <= ex_mem_d;
            mem_wb_q     <= mem_wb_d;
        end
    end

    // Register file and memory writes; contents are not cleared by reset
    always @(posedge clk) begin
        if (wb_we)  Reg[mem_wb_q.dst] <= mem_wb_q.result;
        if (mem_we) Mem[data_addr]    <= ex_mem_q.b;
    end

endmodule

// File: tb/tb_pipe_mips32.sv
// Directed bench for pipe_mips32: small programs loaded hierarchically,
// results compared against a table of hand-computed register/memory values.
module tb_pipe_mips32;
    import pipe_mips32_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic halted;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_mips32 #(.MEM_DEPTH(1024)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .halted (halted)
    );

    typedef struct {
        int          test_id;
        bit          is_mem;
        int          idx;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] HLT_W = 32'hFC00_0000;
    localparam logic [31:0] NOP_W = 32'hF800_0000;

    function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs, input int rt);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'b0};
    endfunction

    function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic load_prog(input int id);
        logic [31:0] p[$];
        p = {};
        case (id)
            0: p = {ri(OP_ADDI, 1, 0, 10), ri(OP_ADDI, 2, 0, 20), ri(OP_ADDI, 3, 0, 25),
                    rr(OP_OR, 15, 7, 7), rr(OP_OR, 15, 7, 7), rr(OP_ADD, 4, 1, 2),
                    rr(OP_OR, 15, 7, 7), rr(OP_ADD, 5, 4, 3), HLT_W};
            1: p = {ri(OP_ADDI, 1, 0, 5), rr(OP_ADD, 2, 1, 1), rr(OP_ADD, 3, 2, 1), HLT_W};
            2: begin
                p = {ri(OP_LW, 2, 1, 0), NOP_W, ri(OP_ADDI, 2, 2, 45), ri(OP_SW, 2, 1, 1), HLT_W};
                dut.Reg[1]   = 32'd120;
                dut.Mem[120] = 32'd85;
            end
            3: begin
                p = {ri(OP_LW, 3, 10, 0), ri(OP_ADDI, 2, 0, 1), rr(OP_MUL, 2, 2, 3),
                     ri(OP_SUBI, 3, 3, 1), ri(OP_BNEQZ, 0, 3, -3), ri(OP_ADDI, 20, 20, 1),
                     ri(OP_SW, 2, 10, -2), HLT_W};
                dut.Reg[10]  = 32'd200;
                dut.Mem[200] = 32'd7;
            end
            default: p = {HLT_W, ri(OP_ADDI, 9, 0, 1)};
        endcase
        foreach (p[i]) dut.Mem[i] = p[i];
    endtask

    // Hold reset, clear memory, preload Reg[k]=k, load program, release at negedge
    task automatic reset_and_load(input int id);
        rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 1024; i++) dut.Mem[i] = 32'd0;
        for (int k = 0; k < 32; k++) dut.Reg[k] = k;
        load_prog(id);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Run until halted with a cycle budget; reports edges taken and branch pulses
    task automatic run_to_halt(input string nm, input int budget, output int cycles, output int taken);
        cycles = 0;
        taken  = 0;
        while (!halted && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (dut.TAKEN_BRANCH) taken++;
        end
        check({nm, "_halted"}, {31'b0, halted}, 32'd1);
    endtask

    initial begin : main
        int cyc, tk;
        logic [31:0] pc_at_halt;
        logic [31:0] fact_exp;
`ifdef MIPS_MUL_EN
        fact_exp = 32'd5040;
`else
        fact_exp = 32'd1;
`endif
        vecs.push_back('{0, 1'b0, 0,   32'd0});
        vecs.push_back('{0, 1'b0, 1,   32'd10});
        vecs.push_back('{0, 1'b0, 2,   32'd20});
        vecs.push_back('{0, 1'b0, 3,   32'd25});
        vecs.push_back('{0, 1'b0, 4,   32'd30});
        vecs.push_back('{0, 1'b0, 5,   32'd55});
        vecs.push_back('{0, 1'b0, 15,  32'd7});
        vecs.push_back('{1, 1'b0, 1,   32'd5});
        vecs.push_back('{1, 1'b0, 2,   32'd10});
        vecs.push_back('{1, 1'b0, 3,   32'd15});
        vecs.push_back('{2, 1'b1, 121, 32'd130});
        vecs.push_back('{2, 1'b0, 2,   32'd130});
        vecs.push_back('{2, 1'b1, 120, 32'd85});
        vecs.push_back('{3, 1'b1, 198, fact_exp});
        vecs.push_back('{3, 1'b0, 20,  32'd21});
        vecs.push_back('{3, 1'b0, 3,   32'd0});

        // Reset state
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rst_pc", dut.PC, 32'd0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        check("rst_taken", {31'b0, dut.TAKEN_BRANCH}, 32'd0);

        // Table-driven programs
        for (int t = 0; t < 4; t++) begin
            reset_and_load(t);
            run_to_halt($sformatf("prog%0d", t), 500, cyc, tk);
            if (t == 0) check("prog0_latency", cyc, 32'd13);
            if (t == 1) check("prog1_latency", cyc, 32'd8);
            if (t == 2) check("prog2_latency", cyc, 32'd9);
            if (t == 3) check("prog3_taken_pulses", tk, 32'd6);
            foreach (vecs[i]) begin
                if (vecs[i].test_id == t) begin
                    if (vecs[i].is_mem)
                        check($sformatf("prog%0d_mem%0d", t, vecs[i].idx), dut.Mem[vecs[i].idx], vecs[i].exp);
                    else
                        check($sformatf("prog%0d_r%0d", t, vecs[i].idx), dut.Reg[vecs[i].idx], vecs[i].exp);
                end
            end
        end

        // HLT followed by ADDI R9: nothing after HLT executes, state frozen
        reset_and_load(4);
        run_to_halt("halt", 100, cyc, tk);
        check("halt_latency", cyc, 32'd5);
        pc_at_halt = dut.PC;
        check("halt_pc", pc_at_halt, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("halt_hold%0d", i), {31'b0, halted}, 32'd1);
        end
        check("halt_pc_frozen", dut.PC, 32'd1);
        check("halt_r9", dut.Reg[9], 32'd9);

        // Async reset while halted drops halted at once
        #2 rst_n = 1'b0;
        #1 check("halt_rst_halted", {31'b0, halted}, 32'd0);

        // Reset mid-program: retained Reg/Mem, PC cleared, rerun gives same results
        reset_and_load(0);
        for (int i = 0; i < 7; i++) @(negedge clk);
        check("mid_pc_before", dut.PC, 32'd7);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_pc", dut.PC, 32'd0);
        check("mid_rst_halted", {31'b0, halted}, 32'd0);
        check("mid_keep_r3", dut.Reg[3], 32'd25);
        check("mid_r4_unwritten", dut.Reg[4], 32'd4);
        check("mid_keep_mem0", dut.Mem[0], ri(OP_ADDI, 1, 0, 10));
        @(negedge clk);
        rst_n = 1'b1;
        run_to_halt("rerun", 500, cyc, tk);
        check("rerun_latency", cyc, 32'd13);
        check("rerun_r4", dut.Reg[4], 32'd30);
        check("rerun_r5", dut.Reg[5], 32'd55);
        check("rerun_r15", dut.Reg[15], 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipe_mips32.md
Name: pipe_mips32

Overview:
- Five-stage in-order MIPS32-subset CPU core (IF, ID, EX, MEM, WB) with a unified word-addressed instruction/data memory and a 32x32 register file.
- Self-contained: the bench loads the program and register contents by hierarchical access, then runs until HLT.
- Sits at the top of the processor sandbox; it has no external bus.

Parameters:
- MEM_DEPTH, 1024, number of 32-bit words in the unified memory `Mem`.
- XLEN, 32, datapath width; fixed at 32.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- halted  output  1  mirrors internal HALTED.

Behaviour:
- Internal names are fixed so the bench can access them hierarchically:
  - Reg[0:31] (32 bits each) and Mem[0:MEM_DEPTH-1] (32 bits each).
  - PC (32-bit word address), HALTED, TAKEN_BRANCH.
- Reset (async, rst_n=0):
  - PC=0, HALTED=0, TAKEN_BRANCH=0, halted=0.
  - All pipeline valid bits cleared (bubbles).
  - Reg and Mem are NOT reset.
- Encoding:
  - opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0] sign-extended to 32 bits.
  - R-type destination is rd; I-type destination is rt.
- Opcodes:
  - ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100, MUL 000101.
  - LW 001000, SW 001001, ADDI 001010, SUBI 001011, SLTI 001100.
  - BNEQZ 001101, BEQZ 001110, HLT 111111.
  - Any other opcode executes as a NOP.
- Arithmetic:
  - Two's complement, results truncated to 32 bits.
  - SLT/SLTI are signed compares giving 1 or 0.
  - MUL keeps the low 32 bits.
- Memory addressing:
  - LW: rt = Mem[rs+imm]. SW: Mem[rs+imm] = rt.
  - Address is taken modulo MEM_DEPTH.
- PC:
  - IF fetches Mem[PC] and sets PC = PC+1 each cycle unless halted or stopped.
- Register file:
  - Read in ID, written in WB.
  - Same-cycle WB write is bypassed to the ID read (write-first).
  - Reg[0] reads as 0; writes to R0 are discarded.
- Forwarding:
  - EX operands are forwarded from EX/MEM (ALU results only) and MEM/WB (ALU or load data).
  - The most recent producer has priority.
  - Dependent ALU instructions therefore need no spacing.
- Load-use:
  - There is no interlock. Software places one independent instruction between an LW and its consumer.
  - If it does not, the consumer reads the stale value.
- Branches:
  - Resolved in EX. BEQZ is taken if rs==0; BNEQZ is taken if rs!=0.
  - Target = (branch PC+1) + imm.
  - When taken, PC loads the target on the same edge and the two younger instructions in IF/ID and ID/EX are squashed to bubbles.
  - TAKEN_BRANCH is high for exactly that one cycle.
- HLT:
  - Decoding HLT in ID stops fetch: PC freezes and IF injects bubbles.
  - HLT flows down the pipe; on its WB edge HALTED=1.
  - Older instructions complete normally.
- After halt:
  - Once HALTED=1, every stage freezes: no Reg/Mem writes and no PC change until reset.
  - Reset mid-operation discards all in-flight instructions.
- Latency: the instruction fetched at cycle n writes back at the edge of cycle n+4.

Optional Feature:
- Macro MIPS_MUL_EN.
  - Defined: MUL opcode 000101 computes rs*rt (low 32 bits) in EX.
  - Undefined: opcode 000101 executes as a NOP and removes the multiplier.

Decomposition:
- Package pipe_mips32_pkg holds:
  - opcode localparams;
  - instruction-class enum (RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP);
  - pipeline-register struct typedefs (IF_ID, ID_EX, EX_MEM, MEM_WB).
- One sub-module, pipe_mips32_alu: combinational; op-class and opcode in, A/B in, result out; it contains the MUL gate.

Test Plan:
- Reg[k]=k, program:
  - ADDI R1,R0,10; ADDI R2,R0,20; ADDI R3,R0,25;
  - OR R15,R7,R7 (x2); ADD R4,R1,R2; OR R15,R7,R7; ADD R5,R4,R3; HLT.
  - Result: R0..R5 = 0,10,20,25,30,55 and halted=1.
- Back-to-back dependency, ADDI R1,R0,5; ADD R2,R1,R1; ADD R3,R2,R1; HLT -> R2=10, R3=15 (forwarding).
- Memory round-trip:
  - Mem[120]=85; LW R2,0(R1) with R1=120; one NOP; ADDI R2,R2,45; SW R2,1(R1); HLT.
  - Result: Mem[121]=130.
- Loop:
  - R10=200, Mem[200]=7; compute factorial with MUL and SUBI plus BNEQZ back-edge; store at Mem[198].
  - Result: Mem[198]=5040; TAKEN_BRANCH pulses 6 times; squashed instructions must not write R-file.
- HLT followed by ADDI R9,R0,1 -> R9 unchanged; PC frozen; halted stays 1 for 10 further cycles.
- Assert rst_n low mid-program -> PC=0, halted=0 immediately; Reg/Mem contents retained; a rerun produces the same results.
